// File: rtl/fulladd_4bit_2_if.sv
// Operand/result bundle for the registered 4-bit adder/subtractor.
// The master drives operands and mode; the slave returns the registered result and flags.
interface fulladd_4bit_2_if;
   logic [3:0] a;
   logic [3:0] b;
   logic       cin;
   logic       gt;
   logic       ls;
   logic       error;
   logic [3:0] sum;
   logic       cout;

   modport master (
      output a, b, cin,
      input  gt, ls, error, sum, cout
   );

   modport slave (
      input  a, b, cin,
      output gt, ls, error, sum, cout
   );
endinterface

// File: rtl/fulladd_4bit_2.sv
// Registered 4-bit ripple-carry adder/subtractor with compare and overflow flags.
// cin=1 computes a - b and reports gt/ls/signed overflow; cin=0 computes a + b and reports carry-out.
module fulladd_4bit_2 (
   input  logic              clk,
   input  logic              rst,
   fulladd_4bit_2_if.slave   bus
);

   typedef struct packed {
      logic [3:0] sum;
      logic       cout;
      logic       gt;
      logic       ls;
      logic       error;
   } result_t;

   localparam result_t RESULT_ZERO = '0;

   logic [3:0] x;
   logic [3:0] y;
   logic [3:0] s;
   logic [4:0] c;
   result_t    res_d;
   result_t    res_q;

   // Subtract mode inverts b and injects the +1 through the bit-0 carry-in.
   always_comb begin
      // NOTE: every variable gets a value on every path so no latch is inferred.
      x     = bus.a;
      y     = bus.cin ? ~bus.b : bus.b;
      c     = '0;
      s     = '0;
      c[0]  = bus.cin;
      for (int i = 0; i < 4; i++) begin
         s[i]   = x[i] ^ y[i] ^ c[i];
         c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
      end
   end

   always_comb begin
      res_d      = RESULT_ZERO;
      res_d.sum  = s;
      res_d.cout = c[4];
      if (bus.cin) begin
         // No borrow with a nonzero difference means a > b; a borrow means a < b.
         res_d.gt    = c[4] & (s != 4'b0000);
         res_d.ls    = ~c[4];
         res_d.error = (x[3] == y[3]) & (s[3] != x[3]);
      end else begin
         res_d.error = c[4];
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignment keeps register updates order-independent.
      if (rst) begin
         res_q <= RESULT_ZERO;
      end else begin
         res_q <= res_d;
      end
   end

   assign bus.sum   = res_q.sum;
   assign bus.cout  = res_q.cout;
   assign bus.gt    = res_q.gt;
   assign bus.ls    = res_q.ls;
   assign bus.error = res_q.error;

endmodule

// File: tb/tb_fulladd_4bit_2.sv
// Directed and exhaustive checks of the registered 4-bit adder/subtractor.
// Inputs change on the falling edge; outputs are sampled 1 ns after the next rising edge.
module tb_fulladd_4bit_2;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   fulladd_4bit_2_if bus ();

   fulladd_4bit_2 dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic r, input logic [3:0] a, input logic [3:0] b, input logic ci);
      @(negedge clk);
      rst     = r;
      bus.a   = a;
      bus.b   = b;
      bus.cin = ci;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [3:0] s, input logic co,
                             input logic g, input logic l, input logic e);
      check({tag, ".sum"},   bus.sum,            s);
      check({tag, ".cout"},  {3'b000, bus.cout},  {3'b000, co});
      check({tag, ".gt"},    {3'b000, bus.gt},    {3'b000, g});
      check({tag, ".ls"},    {3'b000, bus.ls},    {3'b000, l});
      check({tag, ".error"}, {3'b000, bus.error}, {3'b000, e});
   endtask

   initial begin
      int         sa;
      int         sb;
      int         diff;
      logic [3:0] m_sum;
      logic       m_cout;
      logic       m_gt;
      logic       m_ls;
      logic       m_err;

      checks  = 0;
      errors  = 0;
      rst     = 1'b1;
      bus.a   = 4'h0;
      bus.b   = 4'h0;
      bus.cin = 1'b0;

      // Reset wins over live subtract-mode inputs.
      step(1'b1, 4'b0101, 4'b0011, 1'b1);
      expect_out("reset", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

      step(1'b0, 4'b0000, 4'b0000, 1'b1);
      expect_out("sub_eq_zero", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);

      step(1'b0, 4'b0110, 4'b1000, 1'b1);
      expect_out("sub_6_8", 4'b1110, 1'b0, 1'b0, 1'b1, 1'b1);

      step(1'b0, 4'b1000, 4'b0101, 1'b1);
      expect_out("sub_8_5", 4'b0011, 1'b1, 1'b1, 1'b0, 1'b1);

      step(1'b0, 4'b0000, 4'b1111, 1'b1);
      expect_out("sub_0_15", 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0);

      step(1'b0, 4'b1001, 4'b1000, 1'b0);
      expect_out("add_9_8", 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1);

      step(1'b0, 4'b0011, 4'b0100, 1'b0);
      expect_out("add_3_4", 4'b0111, 1'b0, 1'b0, 1'b0, 1'b0);

      step(1'b0, 4'b0111, 4'b0111, 1'b1);
      expect_out("sub_eq_7", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);

      step(1'b0, 4'b1111, 4'b0001, 1'b0);
      expect_out("add_wrap", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);

      // Mid-stream reset clears a non-zero result, then normal updates resume.
      step(1'b1, 4'b1111, 4'b1111, 1'b0);
      expect_out("reset_mid", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

      step(1'b0, 4'b1111, 4'b1111, 1'b0);
      expect_out("add_15_15", 4'b1110, 1'b1, 1'b0, 1'b0, 1'b1);

      // Exhaustive sweep against an arithmetic reference model.
      for (int ci = 0; ci < 2; ci++) begin
         for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
               step(1'b0, 4'(a), 4'(b), 1'(ci));
               if (ci == 1) begin
                  sa     = (a > 7) ? a - 16 : a;
                  sb     = (b > 7) ? b - 16 : b;
                  diff   = sa - sb;
                  m_sum  = 4'((a - b + 16) % 16);
                  m_cout = (a >= b);
                  m_gt   = (a > b);
                  m_ls   = (a < b);
                  m_err  = (diff > 7) || (diff < -8);
               end else begin
                  m_sum  = 4'((a + b) % 16);
                  m_cout = ((a + b) > 15);
                  m_gt   = 1'b0;
                  m_ls   = 1'b0;
                  m_err  = m_cout;
               end
               expect_out($sformatf("sweep_c%0d_a%0d_b%0d", ci, a, b),
                          m_sum, m_cout, m_gt, m_ls, m_err);
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
